// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 1 s prescaler plus a 24-hour packed-BCD clock (hh:mm:ss),
// with a set mode in which push-buttons step the minutes and hours.
module bcd_time_counter #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_tick
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    SET  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [SYNC_STAGES-1:0] r_syncRun;
  logic [SYNC_STAGES-1:0] r_syncSet;
  logic [SYNC_STAGES-1:0] r_syncMin;
  logic [SYNC_STAGES-1:0] r_syncHr;
  logic                   r_minDly;
  logic                   r_hrDly;

  logic [PRE_W-1:0] r_prescale;
  logic [7:0]       r_hours;
  logic [7:0]       r_minutes;
  logic [7:0]       r_seconds;
  logic             r_secTick;

  logic             w_runSync;
  logic             w_setSync;
  logic             w_minSync;
  logic             w_hrSync;
  logic             w_minEdge;
  logic             w_hrEdge;
  logic [PRE_W-1:0] w_prescaleNext;
  logic [7:0]       w_hoursNext;
  logic [7:0]       w_minutesNext;
  logic [7:0]       w_secondsNext;
  logic             w_secTickNext;

  // Steps a packed-BCD value by one, wrapping to 0x00 after maxValue.
  // The units nibble rolls 9->0 into the tens, so no binary value ever appears.
  function automatic logic [7:0] bcdInc(input logic [7:0] value, input logic [7:0] maxValue);
    logic [7:0] result;
    if (value == maxValue) begin
      result = 8'h00;
    end else if (value[3:0] == 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

  assign w_runSync = r_syncRun[SYNC_STAGES-1];
  assign w_setSync = r_syncSet[SYNC_STAGES-1];
  assign w_minSync = r_syncMin[SYNC_STAGES-1];
  assign w_hrSync  = r_syncHr[SYNC_STAGES-1];
  assign w_minEdge = w_minSync & ~r_minDly;
  assign w_hrEdge  = w_hrSync & ~r_hrDly;

  // Synchronise the four asynchronous inputs and keep one delayed copy of each button for edge detection.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_syncRun <= '0;
      r_syncSet <= '0;
      r_syncMin <= '0;
      r_syncHr  <= '0;
      r_minDly  <= 1'b0;
      r_hrDly   <= 1'b0;
    end else begin
      r_syncRun <= {r_syncRun[SYNC_STAGES-2:0], run};
      r_syncSet <= {r_syncSet[SYNC_STAGES-2:0], set_mode};
      r_syncMin <= {r_syncMin[SYNC_STAGES-2:0], inc_min};
      r_syncHr  <= {r_syncHr[SYNC_STAGES-2:0], inc_hr};
      r_minDly  <= w_minSync;
      r_hrDly   <= w_hrSync;
    end
  end

  // Mode register: follows the synchronised levels one cycle later.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= HOLD;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Set mode overrides run; any state can move directly to any other.
  always_comb begin
    w_stateNext = HOLD;
    if (w_setSync) begin
      w_stateNext = SET;
    end else if (w_runSync) begin
      w_stateNext = RUN;
    end
  end

  // Next time and prescaler: count in RUN, step on button edges in SET, freeze in HOLD.
  always_comb begin
    w_prescaleNext = r_prescale;
    w_hoursNext    = r_hours;
    w_minutesNext  = r_minutes;
    w_secondsNext  = r_seconds;
    w_secTickNext  = 1'b0;
    case (r_state)
      SET: begin
        w_prescaleNext = '0;
        w_secondsNext  = 8'h00;
        if (w_minEdge) begin
          w_minutesNext = bcdInc(r_minutes, 8'h59);
        end
        if (w_hrEdge) begin
          w_hoursNext = bcdInc(r_hours, 8'h23);
        end
      end
      RUN: begin
        if (r_prescale == PRE_MAX) begin
          w_prescaleNext = '0;
          w_secTickNext  = 1'b1;
          w_secondsNext  = bcdInc(r_seconds, 8'h59);
          if (r_seconds == 8'h59) begin
            w_minutesNext = bcdInc(r_minutes, 8'h59);
            if (r_minutes == 8'h59) begin
              w_hoursNext = bcdInc(r_hours, 8'h23);
            end
          end
        end else begin
          w_prescaleNext = r_prescale + PRE_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Time-of-day, prescaler and registered tick pulse.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_prescale <= '0;
      r_hours    <= 8'h00;
      r_minutes  <= 8'h00;
      r_seconds  <= 8'h00;
      r_secTick  <= 1'b0;
    end else begin
      r_prescale <= w_prescaleNext;
      r_hours    <= w_hoursNext;
      r_minutes  <= w_minutesNext;
      r_seconds  <= w_secondsNext;
      r_secTick  <= w_secTickNext;
    end
  end

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign sec_tick = r_secTick;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed stimulus with a tick scoreboard for bcd_time_counter
// (TICKS_PER_SEC=4, SYNC_STAGES=2).
module tb_bcd_time_counter;

  localparam int TICKS = 4;

  logic       CLK100MHZ;
  logic       CPU_RESETN;
  logic       run;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hr;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       sec_tick;

  int          checks;
  int          failures;
  logic [23:0] expQ[$];
  logic [23:0] monExp;
  logic        prevTick;
  int          holdTicks;

  bcd_time_counter #(
    .TICKS_PER_SEC(TICKS),
    .SYNC_STAGES  (2)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .run       (run),
    .set_mode  (set_mode),
    .inc_min   (inc_min),
    .inc_hr    (inc_hr),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .sec_tick  (sec_tick)
  );

  // Free-running 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    CLK100MHZ = 1'b0;
    forever #5 CLK100MHZ = ~CLK100MHZ;
  end

  function automatic logic [31:0] nowTime();
    return {8'h00, hours, minutes, seconds};
  endfunction

  function automatic logic [7:0] toBcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic m, input logic h);
    run      = r;
    set_mode = s;
    inc_min  = m;
    inc_hr   = h;
  endtask

  // One button press: high for two cycles, low for two cycles.
  task automatic pulseInc(input logic m, input logic h);
    inc_min = m;
    inc_hr  = h;
    repeat (2) @(negedge CLK100MHZ);
    inc_min = 1'b0;
    inc_hr  = 1'b0;
    repeat (2) @(negedge CLK100MHZ);
  endtask

  task automatic enterSet();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge CLK100MHZ);
  endtask

  // Runs until n ticks are seen, checking first-tick latency and tick spacing,
  // then stops on the last tick's cycle either by dropping run or by raising set_mode.
  task automatic runTicks(input int n, input int expLatency, input bit stopWithSet, input string name);
    int got;
    int cyc;
    int last;
    got  = 0;
    cyc  = 0;
    last = 0;
    run      = 1'b1;
    set_mode = 1'b0;
    while (got < n && cyc < n * TICKS + 20) begin
      @(negedge CLK100MHZ);
      cyc++;
      if (sec_tick) begin
        got++;
        if (got == 1) begin
          checkOutput({name, " first-tick latency"}, 32'(cyc), 32'(expLatency));
        end else begin
          checkOutput({name, " tick interval"}, 32'(cyc - last), 32'(TICKS));
        end
        last = cyc;
      end
    end
    if (got < n) begin
      checkOutput({name, " ticks seen before timeout"}, 32'(got), 32'(n));
    end
    if (stopWithSet) begin
      set_mode = 1'b1;
    end else begin
      run = 1'b0;
    end
  endtask

  // Scoreboard monitor: every sec_tick pops the next expected time and compares it with the outputs.
  always @(negedge CLK100MHZ) begin
    if (sec_tick) begin
      checkOutput("tick not back-to-back", 32'(prevTick), 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected tick: got time 0x%06h, expected no tick", {hours, minutes, seconds});
      end else begin
        monExp = expQ.pop_front();
        checkOutput("tick time", nowTime(), {8'h00, monExp});
      end
    end
    prevTick = sec_tick;
  end

  // Hard stop in case something waits forever.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    checks     = 0;
    failures   = 0;
    prevTick   = 1'b0;
    holdTicks  = 0;
    CPU_RESETN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #2 CPU_RESETN = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    checkOutput("reset time", nowTime(), 32'h000000);
    checkOutput("reset sec_tick", 32'(sec_tick), 32'd0);
    CPU_RESETN = 1'b1;

    // Seconds count in BCD: 01..09 then 10
    expQ.push_back(24'h000001);
    expQ.push_back(24'h000002);
    expQ.push_back(24'h000003);
    expQ.push_back(24'h000004);
    expQ.push_back(24'h000005);
    expQ.push_back(24'h000006);
    expQ.push_back(24'h000007);
    expQ.push_back(24'h000008);
    expQ.push_back(24'h000009);
    expQ.push_back(24'h000010);
    runTicks(10, 7, 1'b0, "count");
    repeat (6) @(negedge CLK100MHZ);
    checkOutput("held after count", nowTime(), 32'h000010);

    // Set 23:59, then run through midnight
    enterSet();
    checkOutput("set entry clears seconds", nowTime(), 32'h000000);
    repeat (23) pulseInc(1'b0, 1'b1);
    repeat (59) pulseInc(1'b1, 1'b0);
    checkOutput("set to 23:59", nowTime(), 32'h235900);
    for (int i = 1; i <= 59; i++) begin
      expQ.push_back({8'h23, 8'h59, toBcd(i)});
    end
    expQ.push_back(24'h000000);
    runTicks(60, 7, 1'b0, "rollover");
    repeat (6) @(negedge CLK100MHZ);
    checkOutput("after midnight", nowTime(), 32'h000000);

    // Minute and hour wrap in set mode; buttons ignored while running
    enterSet();
    repeat (61) pulseInc(1'b1, 1'b0);
    checkOutput("61 minute steps", nowTime(), 32'h000100);
    repeat (25) pulseInc(1'b0, 1'b1);
    checkOutput("25 hour steps", nowTime(), 32'h010100);
    expQ.push_back(24'h010101);
    expQ.push_back(24'h010102);
    fork
      runTicks(2, 7, 1'b0, "run ignores inc");
      begin
        repeat (4) @(negedge CLK100MHZ);
        pulseInc(1'b1, 1'b1);
        pulseInc(1'b1, 1'b1);
      end
    join
    checkOutput("inc ignored in run", nowTime(), 32'h010102);
    enterSet();
    checkOutput("no queued inc", nowTime(), 32'h010100);

    // Pause with the prescaler at 2, then resume and finish the second early
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK100MHZ);
    run = 1'b0;
    repeat (20) begin
      @(negedge CLK100MHZ);
      if (sec_tick) holdTicks++;
    end
    checkOutput("ticks during hold", 32'(holdTicks), 32'd0);
    checkOutput("time frozen in hold", nowTime(), 32'h010100);
    expQ.push_back(24'h010101);
    runTicks(1, 5, 1'b0, "resume");

    // Asynchronous reset between clock edges, then restart from midnight
    expQ.push_back(24'h010102);
    run = 1'b1;
    repeat (6) @(negedge CLK100MHZ);
    #2 CPU_RESETN = 1'b0;
    #1;
    checkOutput("async reset time", nowTime(), 32'h000000);
    checkOutput("async reset sec_tick", 32'(sec_tick), 32'd0);
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    expQ.push_back(24'h000001);
    runTicks(1, 7, 1'b0, "after reset");

    // Simultaneous steps at 05:07, then set mode raised on a tick cycle
    enterSet();
    checkOutput("set entry clears seconds again", nowTime(), 32'h000000);
    repeat (5) pulseInc(1'b0, 1'b1);
    repeat (7) pulseInc(1'b1, 1'b0);
    checkOutput("set to 05:07", nowTime(), 32'h050700);
    pulseInc(1'b1, 1'b1);
    checkOutput("simultaneous steps", nowTime(), 32'h060800);
    expQ.push_back(24'h060801);
    expQ.push_back(24'h060802);
    runTicks(2, 7, 1'b1, "tick into set");
    repeat (6) @(negedge CLK100MHZ);
    checkOutput("set on tick clears seconds", nowTime(), 32'h060800);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
